snake_step_sequencer: RTL and testbench
=======================================

Name: snake_step_sequencer

Overview:
Game-step controller for the snake grid datapath. It divides the pixel clock into game ticks and defers each tick to vertical blanking. Each step is then sequenced as one-cycle strobes: direction latch, head calculation, collision/food check, commit. It also owns the game lifecycle (idle/run/over), the apple-advance request and the speed-up schedule.

Parameters:
TICK_DIV_INIT, 12500000, pixel clocks per game step after start (2 steps/s at 25 MHz)
TICK_DIV_MIN, 2500000, floor for the step period
SPEED_STEP, 500000, period reduction per apple eaten
CNT_W, 24, width of tick counter and period register

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_Start  in  1  start/restart request; level-sampled each cycle
i_Stop  in  1  abort to idle
i_VBlank  in  1  high while raster is outside the active area
i_Collision  in  1  datapath: next head hits body or wall; valid in CHECK
i_Ate  in  1  datapath: next head is on food; valid in CHECK
i_Max_Len  in  1  datapath: snake at maximum length; valid in CHECK
o_Init  out  1  preload snake and reset apple generator
o_Dir_Latch  out  1  latch next direction
o_Head_Calc  out  1  compute next head position/index
o_Check  out  1  datapath presents collision/food result
o_Commit_Move  out  1  move: push head, pop tail
o_Commit_Grow  out  1  grow: push head, keep tail
o_Apple_Advance  out  1  advance apple generator
o_Running  out  1  game active (INIT through COMMIT states)
o_Game_Over  out  1  level, high in OVER
o_Overrun  out  1  sticky: a tick arrived while a step was still pending or executing
o_Step_Count  out  16  steps committed since start; saturates at 16'hFFFF
o_Tick_Div  out  CNT_W  current step period

Behaviour:
- Reset (i_Rst_L=0, asynchronous): state IDLE; all strobes, o_Running, o_Game_Over and o_Overrun = 0; o_Step_Count = 0; tick counter = 0; o_Tick_Div = TICK_DIV_INIT.
- Strobes are Moore outputs, high exactly for the cycle the FSM is in the corresponding state.
- States and transitions:
  - IDLE: i_Start -> INIT.
  - INIT: 1 cycle, o_Init=1. Clears counter, o_Step_Count and o_Overrun. Loads o_Tick_Div=TICK_DIV_INIT. Goes to WAIT.
  - WAIT: counting. Tick -> PEND.
  - PEND: waits for i_VBlank=1, then LATCH.
  - LATCH -> CALC -> CHECK: 1 cycle each.
  - CHECK: samples the inputs.
    - i_Collision=1 -> OVER. Collision beats i_Ate; no commit.
    - Otherwise -> COMMIT.
  - COMMIT, 1 cycle:
    - If i_Ate was sampled: o_Commit_Grow=1 and o_Apple_Advance=1.
    - Otherwise: o_Commit_Move=1.
    - o_Step_Count++ (saturating).
    - If ate: o_Tick_Div = max(o_Tick_Div - SPEED_STEP, TICK_DIV_MIN), computed without underflow.
    - If ate and i_Max_Len -> OVER; else -> WAIT.
  - OVER: o_Game_Over=1. i_Start -> INIT.
- Tick counter:
  - Runs in WAIT, PEND, LATCH, CALC, CHECK and COMMIT, so the step period is exact and independent of sequencing overhead.
  - Tick when counter >= o_Tick_Div-1; counter then clears to 0, otherwise it increments.
  - Using >= handles a period reduction that lands below the current count.
  - A tick occurring outside WAIT sets o_Overrun and is dropped; pending steps never queue beyond one.
- i_Stop in any state other than IDLE:
  - Next state is IDLE.
  - Strobe of the current cycle still asserts; no further strobes.
  - Takes precedence over all other transitions.
  - Counter freezes.
- i_Start held high in IDLE/OVER re-enters INIT only once; INIT is left unconditionally. Start is ignored in running states.
- i_VBlank is ignored outside PEND.
- o_Running = 1 in INIT, WAIT, PEND, LATCH, CALC, CHECK and COMMIT.

Test Plan:
Bench params: TICK_DIV_INIT=8, SPEED_STEP=2, TICK_DIV_MIN=4.
1. Reset: hold i_Rst_L=0, then release -> every output 0, o_Tick_Div=8, state IDLE; o_Init stays 0 with i_Start=0.
2. Start pulse, i_VBlank=1, i_Ate=i_Collision=0 -> o_Init at cycle T; o_Dir_Latch T+10, o_Head_Calc T+11, o_Check T+12, o_Commit_Move T+13, o_Step_Count=1. Next step strobes at T+18..T+21 (period 8).
3. i_VBlank=0 held after a tick -> FSM stays PEND, no strobes; second tick sets o_Overrun=1. Raising i_VBlank -> exactly one step, o_Step_Count increments by 1.
4. i_Ate=1 in three consecutive CHECKs -> o_Commit_Grow and o_Apple_Advance each time, o_Commit_Move never; o_Tick_Div 8->6->4->4. Subsequent step spacing equals the new period.
5. i_Collision=1 and i_Ate=1 in the same CHECK -> no commit/advance strobe, o_Game_Over=1, o_Running=0. i_Start -> o_Init, o_Step_Count=0, o_Tick_Div=8, o_Overrun=0.
6. Abort and reset mid-step:
   - i_Stop asserted in CALC -> CALC strobe only, no o_Check/commit, IDLE next cycle.
   - i_Rst_L dropped mid-CHECK -> all outputs 0 immediately, without waiting for a clock edge.
   - i_Ate=1 with i_Max_Len=1 -> o_Commit_Grow, then OVER.

Source files
------------

// File: rtl/snake_step_sequencer.sv
// Game-step controller for the snake grid: divides the pixel clock into game ticks,
// defers each tick to vertical blanking and sequences one step as single-cycle strobes.
module snake_step_sequencer #(
  parameter int unsigned TICK_DIV_INIT = 12500000,
  parameter int unsigned TICK_DIV_MIN  = 2500000,
  parameter int unsigned SPEED_STEP    = 500000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  input  logic             i_Stop,
  input  logic             i_VBlank,
  input  logic             i_Collision,
  input  logic             i_Ate,
  input  logic             i_Max_Len,
  output logic             o_Init,
  output logic             o_Dir_Latch,
  output logic             o_Head_Calc,
  output logic             o_Check,
  output logic             o_Commit_Move,
  output logic             o_Commit_Grow,
  output logic             o_Apple_Advance,
  output logic             o_Running,
  output logic             o_Game_Over,
  output logic             o_Overrun,
  output logic [15:0]      o_Step_Count,
  output logic [CNT_W-1:0] o_Tick_Div
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT, S_PEND, S_LATCH, S_CALC, S_CHECK, S_COMMIT, S_OVER
  } state_t;

  localparam logic [CNT_W-1:0] L_DIV_INIT   = CNT_W'(TICK_DIV_INIT);
  localparam logic [CNT_W-1:0] L_DIV_MIN    = CNT_W'(TICK_DIV_MIN);
  localparam logic [CNT_W-1:0] L_SPEED_STEP = CNT_W'(SPEED_STEP);

  // max(div - SPEED_STEP, TICK_DIV_MIN) evaluated one bit wider so it cannot wrap.
  function automatic logic [CNT_W-1:0] f_speed_up(input logic [CNT_W-1:0] div);
    if ({1'b0, div} >= ({1'b0, L_DIV_MIN} + {1'b0, L_SPEED_STEP}))
      f_speed_up = div - L_SPEED_STEP;
    else
      f_speed_up = L_DIV_MIN;
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    f_sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tick_div;
  logic [15:0]      r_step_cnt;
  logic             r_ate;
  logic             r_max_len;
  logic             r_overrun;
  logic             r_init, r_dir_latch, r_head_calc, r_check;
  logic             r_commit_move, r_commit_grow, r_apple_adv;
  logic             r_running, r_game_over;
  logic             w_counting;
  logic             w_tick;

  // The counter keeps running through the step sequence so the period stays exact.
  assign w_counting = (r_state inside {S_WAIT, S_PEND, S_LATCH, S_CALC, S_CHECK, S_COMMIT})
                      && !i_Stop;
  assign w_tick     = w_counting && (r_cnt >= r_tick_div - 1'b1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_Start) w_next = S_INIT;
      S_INIT:   w_next = S_WAIT;
      S_WAIT:   if (w_tick) w_next = S_PEND;
      S_PEND:   if (i_VBlank) w_next = S_LATCH;
      S_LATCH:  w_next = S_CALC;
      S_CALC:   w_next = S_CHECK;
      S_CHECK:  w_next = i_Collision ? S_OVER : S_COMMIT;
      S_COMMIT: w_next = (r_ate && r_max_len) ? S_OVER : S_WAIT;
      S_OVER:   if (i_Start) w_next = S_INIT;
      default:  w_next = S_IDLE;
    endcase
    if (i_Stop && (r_state != S_IDLE))
      w_next = S_IDLE;
  end

  // Strobes are registered from the next state so each is high exactly during its state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_tick_div    <= L_DIV_INIT;
      r_step_cnt    <= '0;
      r_ate         <= 1'b0;
      r_max_len     <= 1'b0;
      r_overrun     <= 1'b0;
      r_init        <= 1'b0;
      r_dir_latch   <= 1'b0;
      r_head_calc   <= 1'b0;
      r_check       <= 1'b0;
      r_commit_move <= 1'b0;
      r_commit_grow <= 1'b0;
      r_apple_adv   <= 1'b0;
      r_running     <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_init        <= (w_next == S_INIT);
      r_dir_latch   <= (w_next == S_LATCH);
      r_head_calc   <= (w_next == S_CALC);
      r_check       <= (w_next == S_CHECK);
      r_commit_move <= (w_next == S_COMMIT) && !i_Ate;
      r_commit_grow <= (w_next == S_COMMIT) && i_Ate;
      r_apple_adv   <= (w_next == S_COMMIT) && i_Ate;
      r_running     <= (w_next inside {S_INIT, S_WAIT, S_PEND, S_LATCH, S_CALC, S_CHECK, S_COMMIT});
      r_game_over   <= (w_next == S_OVER);

      if (r_state == S_CHECK) begin
        r_ate     <= i_Ate;
        r_max_len <= i_Max_Len;
      end

      if (w_next == S_INIT) begin
        r_cnt      <= '0;
        r_step_cnt <= '0;
        r_overrun  <= 1'b0;
        r_tick_div <= L_DIV_INIT;
      end else begin
        if (w_counting)
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        // A tick while a step is pending or executing is dropped, not queued.
        if (w_tick && (r_state != S_WAIT))
          r_overrun <= 1'b1;
        if (r_state == S_COMMIT) begin
          r_step_cnt <= f_sat_inc(r_step_cnt);
          if (r_ate)
            r_tick_div <= f_speed_up(r_tick_div);
        end
      end
    end
  end

  assign o_Init          = r_init;
  assign o_Dir_Latch     = r_dir_latch;
  assign o_Head_Calc     = r_head_calc;
  assign o_Check         = r_check;
  assign o_Commit_Move   = r_commit_move;
  assign o_Commit_Grow   = r_commit_grow;
  assign o_Apple_Advance = r_apple_adv;
  assign o_Running       = r_running;
  assign o_Game_Over     = r_game_over;
  assign o_Overrun       = r_overrun;
  assign o_Step_Count    = r_step_cnt;
  assign o_Tick_Div      = r_tick_div;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Bench for snake_step_sequencer: directed scenarios plus random stimulus, all
// outputs compared every cycle against a game-level behavioural model.
module tb_snake_step_sequencer;

  localparam int P_INIT = 8;
  localparam int P_MIN  = 4;
  localparam int P_STEP = 2;
  localparam int P_CW   = 24;

  localparam int G_IDLE = 0;
  localparam int G_RUN  = 1;
  localparam int G_OVER = 2;

  logic            i_Clk, i_Rst_L, i_Start, i_Stop, i_VBlank;
  logic            i_Collision, i_Ate, i_Max_Len;
  logic            o_Init, o_Dir_Latch, o_Head_Calc, o_Check;
  logic            o_Commit_Move, o_Commit_Grow, o_Apple_Advance;
  logic            o_Running, o_Game_Over, o_Overrun;
  logic [15:0]     o_Step_Count;
  logic [P_CW-1:0] o_Tick_Div;

  snake_step_sequencer #(
    .TICK_DIV_INIT(P_INIT), .TICK_DIV_MIN(P_MIN), .SPEED_STEP(P_STEP), .CNT_W(P_CW)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Stop(i_Stop),
    .i_VBlank(i_VBlank), .i_Collision(i_Collision), .i_Ate(i_Ate), .i_Max_Len(i_Max_Len),
    .o_Init(o_Init), .o_Dir_Latch(o_Dir_Latch), .o_Head_Calc(o_Head_Calc), .o_Check(o_Check),
    .o_Commit_Move(o_Commit_Move), .o_Commit_Grow(o_Commit_Grow),
    .o_Apple_Advance(o_Apple_Advance), .o_Running(o_Running), .o_Game_Over(o_Game_Over),
    .o_Overrun(o_Overrun), .o_Step_Count(o_Step_Count), .o_Tick_Div(o_Tick_Div)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: game phase, whether the start-up cycle is in progress, whether a step
  // is waiting for blanking, and how far into the 4-strobe step sequence we are.
  int m_game, m_seq, m_cnt, m_period, m_steps;
  bit m_init, m_pend, m_ovr, m_ate, m_max;

  task automatic model_reset();
    m_game = G_IDLE; m_init = 0; m_pend = 0; m_seq = 0;
    m_cnt = 0; m_period = P_INIT; m_steps = 0; m_ovr = 0; m_ate = 0; m_max = 0;
  endtask

  task automatic model_step();
    bit counting, tick;
    counting = (m_game == G_RUN) && !m_init && !i_Stop;
    tick = 0;
    if (counting) begin
      if (m_cnt + 1 >= m_period) begin tick = 1; m_cnt = 0; end
      else m_cnt++;
    end
    if (m_seq == 4) begin
      if (m_steps < 65535) m_steps++;
      if (m_ate) begin
        m_period = m_period - P_STEP;
        if (m_period < P_MIN) m_period = P_MIN;
      end
    end
    if (i_Stop && m_game != G_IDLE) begin
      m_game = G_IDLE; m_init = 0; m_pend = 0; m_seq = 0;
    end else if (m_game != G_RUN) begin
      if (i_Start) begin
        m_game = G_RUN; m_init = 1; m_cnt = 0; m_steps = 0; m_ovr = 0; m_period = P_INIT;
      end
    end else if (m_init) begin
      m_init = 0;
    end else if (m_seq != 0) begin
      if (tick) m_ovr = 1;
      if (m_seq == 3) begin
        if (i_Collision) begin m_game = G_OVER; m_seq = 0; end
        else begin m_ate = i_Ate; m_max = i_Max_Len; m_seq = 4; end
      end else if (m_seq == 4) begin
        m_seq = 0;
        if (m_ate && m_max) m_game = G_OVER;
      end else begin
        m_seq++;
      end
    end else if (m_pend) begin
      if (tick) m_ovr = 1;
      if (i_VBlank) begin m_pend = 0; m_seq = 1; end
    end else if (tick) begin
      m_pend = 1;
    end
  endtask

  task automatic compare_all();
    chk("init",      o_Init,          (m_game == G_RUN) && m_init);
    chk("dir_latch", o_Dir_Latch,     m_seq == 1);
    chk("head_calc", o_Head_Calc,     m_seq == 2);
    chk("check",     o_Check,         m_seq == 3);
    chk("move",      o_Commit_Move,   (m_seq == 4) && !m_ate);
    chk("grow",      o_Commit_Grow,   (m_seq == 4) && m_ate);
    chk("apple",     o_Apple_Advance, (m_seq == 4) && m_ate);
    chk("running",   o_Running,       m_game == G_RUN);
    chk("game_over", o_Game_Over,     m_game == G_OVER);
    chk("overrun",   o_Overrun,       m_ovr);
    chk("steps",     o_Step_Count,    m_steps);
    chk("tick_div",  o_Tick_Div,      m_period);
  endtask

  int cyc_n = 0;
  int t_init;
  int dl_q[$];
  int mv_q[$];
  int div_q[$];
  int n_grow, n_move, n_apple;
  bit prev_grow = 0;

  // One clock: model advances with the inputs seen at the edge, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge i_Clk);
    if (!i_Rst_L) model_reset();
    else model_step();
    #1;
    cyc_n++;
    compare_all();
    if (o_Init) t_init = cyc_n;
    if (o_Dir_Latch) dl_q.push_back(cyc_n);
    if (o_Commit_Move) begin mv_q.push_back(cyc_n); n_move++; end
    if (o_Commit_Grow) n_grow++;
    if (o_Apple_Advance) n_apple++;
    if (prev_grow) div_q.push_back(int'(o_Tick_Div));
    prev_grow = o_Commit_Grow;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    bit found;
    int saved;
    model_reset();
    i_Rst_L = 0; i_Start = 0; i_Stop = 0; i_VBlank = 0;
    i_Collision = 0; i_Ate = 0; i_Max_Len = 0;

    // Reset and idle with no start
    run(3);
    i_Rst_L = 1;
    run(4);
    chk("rst_tick_div", o_Tick_Div, P_INIT);
    chk("rst_init", o_Init, 0);

    // Basic step timing with blanking always present
    i_VBlank = 1;
    dl_q.delete(); mv_q.delete();
    i_Start = 1; cyc(); i_Start = 0;
    chk("p2_init_seen", t_init, cyc_n);
    run(24);
    if (dl_q.size() >= 2) begin
      chk("p2_latch1", dl_q[0] - t_init, 10);
      chk("p2_latch2", dl_q[1] - t_init, 18);
    end else chk("p2_latch_count", dl_q.size(), 2);
    if (mv_q.size() >= 1) chk("p2_move1", mv_q[0] - t_init, 13);
    else chk("p2_move_count", mv_q.size(), 1);
    chk("p2_steps", o_Step_Count, 2);

    // No blanking: step held pending, second tick flags overrun
    i_VBlank = 0;
    dl_q.delete();
    run(24);
    chk("p3_overrun", o_Overrun, 1);
    chk("p3_no_latch", dl_q.size(), 0);
    saved = o_Step_Count;
    i_VBlank = 1;
    run(6);
    chk("p3_one_step", o_Step_Count, saved + 1);

    // Three apples in a row: period 8 -> 6 -> 4 -> 4
    i_Ate = 1;
    div_q.delete(); dl_q.delete();
    n_move = 0; n_grow = 0; n_apple = 0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      cyc();
      if (div_q.size() == 3) found = 1;
    end
    i_Ate = 0;
    chk("p4_done", found, 1);
    chk("p4_moves", n_move, 0);
    chk("p4_grows", n_grow, 3);
    chk("p4_apples", n_apple, 3);
    if (div_q.size() == 3) begin
      chk("p4_div1", div_q[0], 6);
      chk("p4_div2", div_q[1], 4);
      chk("p4_div3", div_q[2], 4);
    end
    if (dl_q.size() >= 2) chk("p4_spacing", dl_q[1] - dl_q[0], 6);
    else chk("p4_latch_count", dl_q.size(), 2);

    // Collision beats food
    i_Collision = 1; i_Ate = 1;
    n_move = 0; n_grow = 0; n_apple = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (o_Game_Over) found = 1;
    end
    i_Collision = 0; i_Ate = 0;
    chk("p5_over", found, 1);
    chk("p5_no_commit", n_move + n_grow + n_apple, 0);
    chk("p5_not_running", o_Running, 0);
    i_Start = 1; cyc(); i_Start = 0;
    chk("p5_init", o_Init, 1);
    chk("p5_steps", o_Step_Count, 0);
    chk("p5_div", o_Tick_Div, P_INIT);
    chk("p5_ovr", o_Overrun, 0);

    // Stop during CALC
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (o_Head_Calc) found = 1;
    end
    chk("p6_calc_seen", found, 1);
    i_Stop = 1; cyc(); i_Stop = 0;
    chk("p6_stop_check", o_Check, 0);
    chk("p6_stop_running", o_Running, 0);
    cyc();
    chk("p6_stop_idle", o_Check | o_Commit_Move | o_Commit_Grow, 0);

    // Asynchronous reset in the middle of CHECK
    i_Start = 1; cyc(); i_Start = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (o_Check) found = 1;
    end
    chk("p6_check_seen", found, 1);
    #2 i_Rst_L = 0;
    #1;
    model_reset();
    compare_all();
    chk("p6_rst_check", o_Check, 0);
    chk("p6_rst_div", o_Tick_Div, P_INIT);
    run(2);
    i_Rst_L = 1;

    // Apple at maximum length ends the game after growing
    i_Start = 1; cyc(); i_Start = 0;
    i_Ate = 1; i_Max_Len = 1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (o_Commit_Grow) found = 1;
    end
    chk("p6_grow_seen", found, 1);
    cyc();
    chk("p6_maxlen_over", o_Game_Over, 1);
    i_Ate = 0; i_Max_Len = 0;

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      i_Rst_L     = ($urandom_range(0, 499) != 0);
      i_Start     = ($urandom_range(0, 19) == 0);
      i_Stop      = ($urandom_range(0, 99) == 0);
      i_VBlank    = ($urandom_range(0, 1) == 1);
      i_Collision = ($urandom_range(0, 15) == 0);
      i_Ate       = ($urandom_range(0, 3) == 0);
      i_Max_Len   = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
